// File: rtl/rv32i_lsu_pkg.sv
// Shared RV32I definitions: memory-op encodings and LSU state.
// Imported by the load/store unit and its lane-alignment helper.
package rv32i_lsu_pkg;

  localparam logic [3:0] MEM_LB  = 4'b0000;
  localparam logic [3:0] MEM_LH  = 4'b0001;
  localparam logic [3:0] MEM_LW  = 4'b0010;
  localparam logic [3:0] MEM_LBU = 4'b1000;
  localparam logic [3:0] MEM_LHU = 4'b1001;
  localparam logic [3:0] MEM_SB  = 4'b0111;
  localparam logic [3:0] MEM_SH  = 4'b0100;
  localparam logic [3:0] MEM_SW  = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } lsu_state_e;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational lane logic for the LSU: op decode, store lanes,
// load byte/half extraction and sign/zero extension.
module rv32i_lsu_align
  import rv32i_lsu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_store,
  output logic        o_illegal,
  output logic        o_misaligned,
  output logic [31:0] o_ld_data
);

  logic is_b;
  logic is_h;
  logic is_w;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    is_b      = 1'b0;
    is_h      = 1'b0;
    is_w      = 1'b0;
    o_store   = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      MEM_LB:  is_b = 1'b1;
      MEM_LBU: is_b = 1'b1;
      MEM_LH:  is_h = 1'b1;
      MEM_LHU: is_h = 1'b1;
      MEM_LW:  is_w = 1'b1;
      MEM_SB:  begin is_b = 1'b1; o_store = 1'b1; end
      MEM_SH:  begin is_h = 1'b1; o_store = 1'b1; end
      MEM_SW:  begin is_w = 1'b1; o_store = 1'b1; end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_misaligned = (is_h & i_off[0]) | (is_w & (|i_off));

  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_wdata;
    unique case (1'b1)
      is_b: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      is_h: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'hF;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    ld_b = i_rdata[7:0];
    case (i_ld_off)
      2'd0:    ld_b = i_rdata[7:0];
      2'd1:    ld_b = i_rdata[15:8];
      2'd2:    ld_b = i_rdata[23:16];
      default: ld_b = i_rdata[31:24];
    endcase
  end

  assign ld_h = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_op)
      MEM_LB:  o_ld_data = {{24{ld_b[7]}}, ld_b};
      MEM_LBU: o_ld_data = {24'd0, ld_b};
      MEM_LH:  o_ld_data = {{16{ld_h[15]}}, ld_h};
      MEM_LHU: o_ld_data = {16'd0, ld_h};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: accepts one memory op from execute, runs a
// req/gnt + rvalid bus transaction and returns aligned load data.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  input  logic        i_flush,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_st_done,
  output logic        o_misaligned,
  output logic        o_illegal,
  output logic        o_bus_err,
  output logic [31:0] o_fault_addr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        st_done_q, st_done_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] fault_q, fault_d;

  logic [3:0]  a_be;
  logic [31:0] a_wdata;
  logic        a_store;
  logic        a_illegal;
  logic        a_mis;
  logic [31:0] a_ld_data;
  logic        expired;

  rv32i_lsu_align u_align (
    .i_op        (i_op),
    .i_off       (i_addr[1:0]),
    .i_wdata     (i_wdata),
    .i_ld_op     (op_q),
    .i_ld_off    (addr_q[1:0]),
    .i_rdata     (i_dmem_rdata),
    .o_be        (a_be),
    .o_wdata     (a_wdata),
    .o_store     (a_store),
    .o_illegal   (a_illegal),
    .o_misaligned(a_mis),
    .o_ld_data   (a_ld_data)
  );

  assign expired = (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    op_d       = op_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    st_done_d  = 1'b0;
    mis_d      = 1'b0;
    ill_d      = 1'b0;
    bus_err_d  = 1'b0;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          if (a_illegal) begin
            ill_d   = 1'b1;
            fault_d = i_addr;
          end else if (a_mis) begin
            mis_d   = 1'b1;
            fault_d = i_addr;
          end else begin
            addr_d  = i_addr;
            be_d    = a_be;
            wdata_d = a_wdata;
            we_d    = a_store;
            op_d    = i_op;
            rd_d    = i_rd;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (i_dmem_gnt) begin
          cnt_d = '0;
          if (we_q) begin
            st_done_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = i_flush ? S_DRAIN : S_WAIT;
          end
        end else if (i_flush) begin
          state_d = S_IDLE;
        end else if (expired) begin
          bus_err_d = 1'b1;
          fault_d   = addr_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (i_dmem_rvalid) begin
          // a flush arriving with the data still consumes the response
          state_d = S_IDLE;
          if (!i_flush) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = a_ld_data;
          end
        end else if (i_flush) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (expired) begin
          bus_err_d = 1'b1;
          fault_d   = addr_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_dmem_rvalid || expired) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      st_done_q  <= 1'b0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      fault_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      st_done_q  <= st_done_d;
      mis_q      <= mis_d;
      ill_q      <= ill_d;
      bus_err_q  <= bus_err_d;
      fault_q    <= fault_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_dmem_req   = (state_q == S_REQ);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[31:2], 2'b00};
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_wb_data    = wb_data_q;
  assign o_st_done    = st_done_q;
  assign o_misaligned = mis_q;
  assign o_illegal    = ill_q;
  assign o_bus_err    = bus_err_q;
  assign o_fault_addr = fault_q;

endmodule
